// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by the hex encoder and the readback decoder.
// Glyphs are active-low {g,f,e,d,c,b,a}: a 0 bit means the segment is lit.
package seg7_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned NIB_W = 4;
   localparam int unsigned CNT_W = 4;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h18;
   localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
   localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
   localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
   localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
   localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PRESENT = 1'b1
   } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational glyph-to-nibble decoder.
// Ports: i_seg      - active-low {g,f,e,d,c,b,a} pattern
//        o_nibble_c - decoded hex value (0 for unknown glyphs)
//        o_valid_c  - 1 when i_seg is one of the 16 hex glyphs
module seg7_to_hex
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] i_seg,
   output logic [NIB_W-1:0] o_nibble_c,
   output logic             o_valid_c
);

   always_comb begin
      o_nibble_c = '0;
      o_valid_c  = 1'b1;
      case (i_seg)
         SEG_0:   o_nibble_c = 4'h0;
         SEG_1:   o_nibble_c = 4'h1;
         SEG_2:   o_nibble_c = 4'h2;
         SEG_3:   o_nibble_c = 4'h3;
         SEG_4:   o_nibble_c = 4'h4;
         SEG_5:   o_nibble_c = 4'h5;
         SEG_6:   o_nibble_c = 4'h6;
         SEG_7:   o_nibble_c = 4'h7;
         SEG_8:   o_nibble_c = 4'h8;
         SEG_9:   o_nibble_c = 4'h9;
         SEG_A:   o_nibble_c = 4'hA;
         SEG_B:   o_nibble_c = 4'hB;
         SEG_C:   o_nibble_c = 4'hC;
         SEG_D:   o_nibble_c = 4'hD;
         SEG_E:   o_nibble_c = 4'hE;
         SEG_F:   o_nibble_c = 4'hF;
         default: o_valid_c  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Reads a scanned 7-segment display bus back into hex nibbles and presents each
// complete frame as one packed word on a valid/ready interface.
// Ports: clk, reset (sync, active-high)
//        seg_valid/seg_digit/seg - scanned display sample
//        word_valid/word_ready/word - packed frame handshake, digit i at [4i+3:4i]
//        err_mask - per-digit illegal glyph flags, err - OR of err_mask
module seg7_frame_decoder
   import seg7_pkg::*;
#(
   parameter  int unsigned NUM_DIGITS = 4,
   parameter  int unsigned STABLE_CNT = 3,
   localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    seg_valid,
   input  logic [DW-1:0]           seg_digit,
   input  logic [SEG_W-1:0]        seg,
   output logic                    word_valid,
   input  logic                    word_ready,
   output logic [4*NUM_DIGITS-1:0] word,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic                    err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e                  r_state;
   logic [DW-1:0]           r_hold_digit;
   logic [SEG_W-1:0]        r_hold_seg;
   logic [CNT_W-1:0]        r_run_cnt;
   logic [NIB_W-1:0]        r_slot [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   r_slot_err;
   logic [NUM_DIGITS-1:0]   r_written;
   logic [4*NUM_DIGITS-1:0] r_word;
   logic [NUM_DIGITS-1:0]   r_err_mask;
   logic                    r_word_valid;

   logic [NIB_W-1:0]        w_nibble;
   logic                    w_glyph_ok;
   logic                    w_in_range;
   logic                    w_match;
   logic [CNT_W-1:0]        w_cnt_next;
   logic                    w_accept;
   logic                    w_load;
   state_e                  w_state_next;
   logic                    w_word_valid_next;
   logic [NUM_DIGITS-1:0]   w_written_next;
   logic [4*NUM_DIGITS-1:0] w_slot_word;

   seg7_to_hex u_to_hex (
      .i_seg      (seg),
      .o_nibble_c (w_nibble),
      .o_valid_c  (w_glyph_ok)
   );

   // Stability filter: saturating run length of identical (digit, seg) beats.
   // Accept fires only on the beat that moves the run onto STABLE_CNT.
   always_comb begin
      w_in_range = (32'(seg_digit) < NUM_DIGITS);
      w_match    = (seg_digit == r_hold_digit) && (seg == r_hold_seg);
      w_cnt_next = CNT_W'(1);
      if (w_match) begin
         w_cnt_next = (r_run_cnt == CNT_MAX) ? r_run_cnt : r_run_cnt + CNT_W'(1);
      end
      w_accept = seg_valid && w_in_range
              && (w_cnt_next == CNT_W'(STABLE_CNT))
              && !(w_match && (r_run_cnt == CNT_W'(STABLE_CNT)));
   end

   // Frame FSM: load when all slots are written, hold until consumed.
   always_comb begin
      w_state_next      = r_state;
      w_load            = 1'b0;
      w_word_valid_next = r_word_valid;
      case (r_state)
         ST_COLLECT: begin
            if (&r_written) begin
               w_load            = 1'b1;
               w_word_valid_next = 1'b1;
               w_state_next      = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (r_word_valid && word_ready) begin
               if (&r_written) begin
                  w_load = 1'b1;
               end else begin
                  w_word_valid_next = 1'b0;
                  w_state_next      = ST_COLLECT;
               end
            end
         end
         default: w_state_next = ST_COLLECT;
      endcase
   end

   // A slot accepted on a load edge belongs to the next frame: clear, then set.
   always_comb begin
      w_written_next = r_written;
      if (w_load) begin
         w_written_next = '0;
      end
      if (w_accept) begin
         w_written_next[seg_digit] = 1'b1;
      end
   end

   always_comb begin
      w_slot_word = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_slot_word[4*i +: 4] = r_slot[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_COLLECT;
         r_hold_digit <= '0;
         r_hold_seg   <= '0;
         r_run_cnt    <= '0;
         r_slot       <= '{default: '0};
         r_slot_err   <= '0;
         r_written    <= '0;
         r_word       <= '0;
         r_err_mask   <= '0;
         r_word_valid <= 1'b0;
      end else begin
         if (seg_valid) begin
            if (!w_in_range) begin
               r_run_cnt <= '0;
            end else begin
               r_hold_digit <= seg_digit;
               r_hold_seg   <= seg;
               r_run_cnt    <= w_cnt_next;
            end
         end
         if (w_accept) begin
            r_slot[seg_digit]     <= w_nibble;
            r_slot_err[seg_digit] <= !w_glyph_ok;
         end
         if (w_load) begin
            r_word     <= w_slot_word;
            r_err_mask <= r_slot_err;
         end
         r_written    <= w_written_next;
         r_state      <= w_state_next;
         r_word_valid <= w_word_valid_next;
      end
   end

   assign word_valid = r_word_valid;
   assign word       = r_word;
   assign err_mask   = r_err_mask;
   assign err        = |r_err_mask;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: a 4-digit instance for most sequences and a
// 3-digit instance for the out-of-range index case.
module tb_seg7_frame_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sv4, wr4, wv4, err4;
   logic [1:0]  sd4;
   logic [6:0]  sg4;
   logic [15:0] word4;
   logic [3:0]  em4;
   logic        sv3, wr3, wv3, err3;
   logic [1:0]  sd3;
   logic [6:0]  sg3;
   logic [11:0] word3;
   logic [2:0]  em3;

   int n_tests = 0;
   int n_fail  = 0;

   seg7_frame_decoder #(.NUM_DIGITS(4), .STABLE_CNT(3)) u_dut4 (
      .clk(clk), .reset(reset), .seg_valid(sv4), .seg_digit(sd4), .seg(sg4),
      .word_valid(wv4), .word_ready(wr4), .word(word4), .err_mask(em4), .err(err4)
   );

   seg7_frame_decoder #(.NUM_DIGITS(3), .STABLE_CNT(3)) u_dut3 (
      .clk(clk), .reset(reset), .seg_valid(sv3), .seg_digit(sd3), .seg(sg3),
      .word_valid(wv3), .word_ready(wr3), .word(word3), .err_mask(em3), .err(err3)
   );

   typedef struct {
      logic [27:0] segs;   // digit i pattern at [7i+6:7i]
      logic [15:0] w;
      logic [3:0]  m;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n consecutive seg_valid beats on the chosen instance
   task automatic beats(input int sel, input logic [1:0] d, input logic [6:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         if (sel == 4) begin
            sv4 = 1'b1; sd4 = d; sg4 = s;
         end else begin
            sv3 = 1'b1; sd3 = d; sg3 = s;
         end
         tick();
      end
      sv4 = 1'b0;
      sv3 = 1'b0;
   endtask

   task automatic send_frame4(input logic [27:0] segs);
      logic [27:0] t;
      t = segs;
      for (int d = 0; d < 4; d++) begin
         beats(4, 2'(d), t[7*d +: 7], 3);
      end
   endtask

   task automatic wait_valid4(input string name);
      int c;
      c = 0;
      while (!wv4 && c < 20) begin
         tick();
         c++;
      end
      check(name, 32'(wv4), 32'd1);
   endtask

   task automatic handshake4();
      wr4 = 1'b1;
      tick();
      wr4 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [27:0] fr;
      vecs[0] = '{{7'h30, 7'h24, 7'h79, 7'h40}, 16'h3210, 4'b0000};
      vecs[1] = '{{7'h78, 7'h02, 7'h12, 7'h19}, 16'h7654, 4'b0000};
      vecs[2] = '{{7'h08, 7'h7F, 7'h18, 7'h00}, 16'hA098, 4'b0100};
      vecs[3] = '{{7'h06, 7'h21, 7'h46, 7'h03}, 16'hEDCB, 4'b0000};
      vecs[4] = '{{7'h7F, 7'h7F, 7'h40, 7'h0E}, 16'h000F, 4'b1100};
      vecs[5] = '{{7'h0E, 7'h40, 7'h7F, 7'h01}, 16'hF000, 4'b0011};

      reset = 1'b1;
      sv4 = 1'b0; sd4 = '0; sg4 = '0; wr4 = 1'b0;
      sv3 = 1'b0; sd3 = '0; sg3 = '0; wr3 = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_valid",  32'(wv4),   32'd0);
      check("rst_word",   32'(word4), 32'd0);
      check("rst_mask",   32'(em4),   32'd0);
      check("rst_err",    32'(err4),  32'd0);
      check("rst_valid3", 32'(wv3),   32'd0);

      // Table: full frames, latency t+2, decode and error flags
      for (int v = 0; v < 6; v++) begin
         send_frame4(vecs[v].segs);
         check($sformatf("v%0d_lat_t1", v), 32'(wv4), 32'd0);
         tick();
         check($sformatf("v%0d_lat_t2", v), 32'(wv4), 32'd1);
         check($sformatf("v%0d_word", v), 32'(word4), 32'(vecs[v].w));
         check($sformatf("v%0d_mask", v), 32'(em4), 32'(vecs[v].m));
         check($sformatf("v%0d_err", v), 32'(err4), 32'(|vecs[v].m));
         handshake4();
         check($sformatf("v%0d_drop", v), 32'(wv4), 32'd0);
      end

      // Glitch filter: only the final stable 79 run lands; 2-beat 24 run ignored
      beats(4, 2'd1, 7'h79, 2);
      beats(4, 2'd1, 7'h24, 1);
      beats(4, 2'd1, 7'h79, 3);
      beats(4, 2'd1, 7'h24, 2);
      beats(4, 2'd0, 7'h40, 3);
      beats(4, 2'd2, 7'h24, 3);
      beats(4, 2'd3, 7'h30, 3);
      wait_valid4("glitch_valid");
      check("glitch_word", 32'(word4), 32'h3210);
      handshake4();

      // Long identical run must not re-accept
      send_frame4(vecs[0].segs);
      beats(4, 2'd3, 7'h30, 4);
      wait_valid4("reacc_valid");
      check("reacc_word", 32'(word4), 32'h3210);
      handshake4();
      check("reacc_drop", 32'(wv4), 32'd0);
      beats(4, 2'd0, 7'h40, 3);
      beats(4, 2'd1, 7'h79, 3);
      beats(4, 2'd2, 7'h24, 3);
      for (int k = 0; k < 6; k++) tick();
      check("reacc_no_frame", 32'(wv4), 32'd0);
      beats(4, 2'd3, 7'h19, 3);
      wait_valid4("reacc_valid2");
      check("reacc_word2", 32'(word4), 32'h4210);
      handshake4();

      // Backpressure: second frame captured while first is held
      send_frame4(vecs[0].segs);
      wait_valid4("bp_valid");
      fr = {7'h21, 7'h46, 7'h03, 7'h08};
      for (int c = 0; c < 20; c++) begin
         if (c < 12) begin
            sv4 = 1'b1; sd4 = 2'(c / 3); sg4 = fr[7*(c/3) +: 7];
         end else begin
            sv4 = 1'b0;
         end
         tick();
         check("bp_hold_word", 32'(word4), 32'h3210);
         check("bp_hold_valid", 32'(wv4), 32'd1);
      end
      sv4 = 1'b0;
      handshake4();
      check("bp_b2b_valid", 32'(wv4), 32'd1);
      check("bp_b2b_word", 32'(word4), 32'hDCBA);
      check("bp_b2b_mask", 32'(em4), 32'd0);
      handshake4();
      check("bp_drop", 32'(wv4), 32'd0);

      // Out-of-range index clears the run (3-digit instance)
      beats(3, 2'd0, 7'h40, 3);
      beats(3, 2'd1, 7'h79, 3);
      beats(3, 2'd2, 7'h24, 2);
      beats(3, 2'd3, 7'h24, 1);
      beats(3, 2'd2, 7'h24, 2);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("oor_no_frame", 32'(wv3), 32'd0);
      end
      beats(3, 2'd2, 7'h24, 1);
      check("oor_lat_t1", 32'(wv3), 32'd0);
      tick();
      check("oor_lat_t2", 32'(wv3), 32'd1);
      check("oor_word", 32'(word3), 32'h210);
      check("oor_mask", 32'(em3), 32'd0);
      wr3 = 1'b1;
      tick();
      wr3 = 1'b0;
      check("oor_drop", 32'(wv3), 32'd0);

      // Reset mid-frame discards partial slots
      beats(4, 2'd0, 7'h40, 3);
      beats(4, 2'd1, 7'h79, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", 32'(wv4), 32'd0);
      check("mid_rst_word", 32'(word4), 32'd0);
      beats(4, 2'd2, 7'h24, 3);
      beats(4, 2'd3, 7'h30, 3);
      for (int k = 0; k < 6; k++) tick();
      check("mid_rst_no_frame", 32'(wv4), 32'd0);
      beats(4, 2'd0, 7'h40, 3);
      beats(4, 2'd1, 7'h79, 3);
      wait_valid4("mid_rst_valid2");
      check("mid_rst_word2", 32'(word4), 32'h3210);
      handshake4();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
Inverse of the display path: captures active-low 7-segment patterns, {g,f,e,d,c,b,a}, from a scanned multi-digit display bus and turns them back into hex nibbles.
- Each pattern is filtered for stability, then written into a per-digit slot.
- When every digit has been captured, the slots are presented as one packed word on a valid/ready output.
- Used by the board-level self-check and the PS/2 lab monitor to read back what the display actually shows.

Parameters:
NUM_DIGITS, 4, number of display digits per frame (2..8)
STABLE_CNT, 3, consecutive identical seg_valid beats required before a pattern is accepted (1..15)
DW, $clog2(NUM_DIGITS), width of the digit index (derived, not overridable)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
seg_valid  input  1  seg/seg_digit carry a sample this cycle
seg_digit  input  DW  index of the digit being driven
seg  input  7  segment pattern, {g,f,e,d,c,b,a}, 0 = segment lit
word_valid  output  1  packed frame available
word_ready  input  1  consumer accepts frame when high with word_valid
word  output  4*NUM_DIGITS  digit i in bits [4i+3:4i]
err_mask  output  NUM_DIGITS  bit i = digit i pattern was not a legal hex glyph
err  output  1  OR of err_mask (combinational from registered err_mask)

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset: word_valid=0, word=0, err_mask=0, written slots cleared, stability run cleared, state COLLECT.
- Decode table: legal patterns map as 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F (hex, 7-bit). Every other pattern decodes to nibble 0 with the invalid flag set.
- Stability filter: holds the last (seg_digit, seg) pair and a saturating run counter.
  - A seg_valid beat that matches the held pair increments the counter.
  - A beat that differs reloads the pair and sets the counter to 1.
  - Cycles with seg_valid=0 leave the filter untouched.
- Accept: occurs on the beat where the counter reaches exactly STABLE_CNT, and only once per run. Further identical beats do not re-accept.
  - The slot write lands at the next edge: slot[d] <= nibble, written[d] <= 1, slot_err[d] <= invalid.
- Out-of-range index (seg_digit >= NUM_DIGITS): the beat is dropped and the run counter is cleared to 0.
- A slot may be rewritten before the frame completes; the last accepted value wins.
- FSM COLLECT:
  - When written is all ones, the next edge loads word/err_mask from the slots, sets word_valid=1, clears written, and moves to PRESENT.
- FSM PRESENT:
  - word, err_mask and word_valid are held stable until word_valid && word_ready.
  - On that handshake, if written is all ones in the same cycle, reload directly and stay in PRESENT (back-to-back frames). Otherwise clear word_valid and return to COLLECT.
  - Captures continue into the slots during PRESENT. A completed frame waits (no loss, no overwrite of word) until the handshake.
- Latency: the accepting beat in cycle t completing the last missing slot gives word_valid=1 in cycle t+2.
- Simultaneous accept and load: a slot accepted in the same cycle as a load goes into the next frame. written is cleared, then that bit is set.
- Reset mid-frame: all partial slots are discarded; reset has priority over every other update.

Decomposition:
- Shared package seg7_pkg:
  - SEG_0..SEG_F 7-bit active-low glyph constants, shared with the existing hex encoder so both directions use one table.
  - SEG_BLANK = 7'h7F.
- Sub-module seg7_to_hex: purely combinational, seg in, nibble + valid out. This module instantiates it once.

Test Plan:
- Reset, then a clean frame: send digit 0..3 with patterns 40,79,24,30, each on 3 consecutive seg_valid beats -> word_valid at t+2 after the last accepting beat, word=16'h3210, err=0.
- Glitch filter: digit 1 driven 79,79,24,79,79,79 -> only the final run is accepted, slot 1 = 1. A 2-beat run of 24 (STABLE_CNT=3) is never accepted.
- Invalid glyph: digit 2 = 7F for 3 beats, others legal -> word nibble 2 = 0, err_mask=4'b0100, err=1.
- Backpressure: word_ready=0 for 20 cycles while a second full frame (A,b,C,d) is captured -> first word held unchanged. Handshake then reloads back-to-back with 16'hDCBA, word_valid never drops.
- Out-of-range: NUM_DIGITS=3, seg_digit=3 beats interleaved in a stable run -> run resets, no slot written, frame completes only after 3 uninterrupted beats.
- Reset mid-frame: slots 0,1 written, reset for 1 cycle, then only slots 2,3 sent -> no word_valid until slots 0,1 are recaptured.
